// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state encoding and default parameters for pipeline_ctrl.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 32;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, stall/flush controls and perf counters of pipeline_ctrl.
//   master: pipeline side, drives hazards/dmem status, receives controls and counters
//   slave : pipeline_ctrl, receives hazards/dmem status, drives controls and counters
interface pipeline_ctrl_if import pipe_ctrl_pkg::*; #(parameter int CNT_W = CNT_W_DEF);
    logic             load_use_hazard;
    logic             ex_redirect;
    logic             dmem_req;
    logic             dmem_ready;
    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             stall_ex_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_mem_wb;
    logic             pc_redirect;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    modport master (
        output load_use_hazard, ex_redirect, dmem_req, dmem_ready,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, flush_mem_wb, pc_redirect, mem_fault, stall_cycles, flush_events
    );
    modport slave (
        input  load_use_hazard, ex_redirect, dmem_req, dmem_ready,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, flush_mem_wb, pc_redirect, mem_fault, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
//   clk, rst (async, active-high), en (count this cycle), cnt (current value)
module sat_counter #(parameter int W = 32) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (en && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush scheduler merging load-use, EX redirect and MEM wait hazards.
//   clk, rst (async, active-high)
//   bus (slave): hazard/dmem inputs in; per-register stall/flush, pc_redirect,
//                mem_fault and saturating stall_cycles/flush_events out
module pipeline_ctrl import pipe_ctrl_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    state_e          state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            wait_now, freeze, act, frz, redir, lu;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wait_now   = bus.dmem_req & ~bus.dmem_ready;
        unique case (state_q)
            ST_RUN:
                if (wait_now) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            ST_MEM_WAIT:
                if (!wait_now) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(TIMEOUT - 1))
                    state_d = ST_FAULT;
                else
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RUN;
        endcase
        freeze = wait_now | (state_q == ST_FAULT);
        // Controls are forced low while reset is held, even though state is already RUN.
        act   = ~rst;
        frz   = act & freeze;
        // A frozen EX keeps its redirect, so it simply takes effect once the freeze lifts.
        redir = act & ~freeze & bus.ex_redirect;
        // Load-use loses to a redirect because the dependent instruction gets flushed anyway.
        lu    = act & ~freeze & ~bus.ex_redirect & bus.load_use_hazard;
    end
    assign bus.stall_pc     = frz | lu;
    assign bus.stall_if_id  = frz | lu;
    assign bus.stall_id_ex  = frz;
    assign bus.stall_ex_mem = frz;
    assign bus.flush_mem_wb = frz;
    assign bus.flush_if_id  = redir;
    assign bus.flush_id_ex  = redir | lu;
    assign bus.pc_redirect  = redir;
    assign bus.mem_fault    = state_q == ST_FAULT;
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (bus.stall_pc),
        .cnt (bus.stall_cycles)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (bus.pc_redirect),
        .cnt (bus.flush_events)
    );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: self-checking bench for pipeline_ctrl (default instance plus TIMEOUT=4/CNT_W=4 instance).
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;
    // control vector order: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //                        flush_if_id, flush_id_ex, flush_mem_wb, pc_redirect, mem_fault}
    localparam logic [8:0] ID = 9'b000000000;
    localparam logic [8:0] LU = 9'b110001000;
    localparam logic [8:0] RD = 9'b000011010;
    localparam logic [8:0] FZ = 9'b111100100;
    localparam logic [8:0] FT = 9'b111100101;
    typedef struct packed {
        logic       lu;
        logic       exr;
        logic       req;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lu = 1'b0, exr = 1'b0, req = 1'b0, rdy = 1'b0;
    int total = 0;
    int bad = 0;
    logic [8:0] sb[$];
    vec_t vecs[11];
    pipeline_ctrl_if #(.CNT_W(32)) a_if();
    pipeline_ctrl_if #(.CNT_W(4))  b_if();
    assign a_if.load_use_hazard = lu;
    assign a_if.ex_redirect     = exr;
    assign a_if.dmem_req        = req;
    assign a_if.dmem_ready      = rdy;
    assign b_if.load_use_hazard = lu;
    assign b_if.ex_redirect     = exr;
    assign b_if.dmem_req        = req;
    assign b_if.dmem_ready      = rdy;
    pipeline_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(a_if.slave));
    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
    wire [8:0] a_ctrl = {a_if.stall_pc, a_if.stall_if_id, a_if.stall_id_ex, a_if.stall_ex_mem,
                         a_if.flush_if_id, a_if.flush_id_ex, a_if.flush_mem_wb, a_if.pc_redirect, a_if.mem_fault};
    wire [8:0] b_ctrl = {b_if.stall_pc, b_if.stall_if_id, b_if.stall_id_ex, b_if.stall_ex_mem,
                         b_if.flush_if_id, b_if.flush_id_ex, b_if.flush_mem_wb, b_if.pc_redirect, b_if.mem_fault};
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic step(input logic l, input logic e, input logic q, input logic r,
                        input logic [8:0] exp, input string nm);
        @(negedge clk);
        lu = l; exr = e; req = q; rdy = r;
        sb.push_back(exp);
        #2;
        chk(nm, 32'(a_ctrl), 32'(sb.pop_front()));
    endtask
    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1; lu = 1'b1; exr = 1'b1; req = 1'b1; rdy = 1'b0;
        #1;
        chk({nm, "_a_ctrl"}, 32'(a_ctrl), 32'(ID));
        chk({nm, "_b_ctrl"}, 32'(b_ctrl), 32'(ID));
        chk({nm, "_a_stall"}, a_if.stall_cycles, 0);
        chk({nm, "_a_flush"}, a_if.flush_events, 0);
        @(negedge clk);
        lu = 1'b0; exr = 1'b0; req = 1'b0;
        rst = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0]  = {4'b0000, ID};
        vecs[1]  = {4'b1000, LU};
        vecs[2]  = {4'b0100, RD};
        vecs[3]  = {4'b1100, RD};
        vecs[4]  = {4'b0011, ID};
        vecs[5]  = {4'b1011, LU};
        vecs[6]  = {4'b0110, FZ};
        vecs[7]  = {4'b0111, RD};
        vecs[8]  = {4'b1010, FZ};
        vecs[9]  = {4'b0000, ID};
        vecs[10] = {4'b0100, RD};
        do_reset("rst0");
        step(1, 0, 0, 0, LU, "lu_one");
        step(0, 0, 0, 0, ID, "lu_off");
        chk("lu_stall_cnt", a_if.stall_cycles, 1);
        step(1, 1, 0, 0, RD, "redir_lu");
        step(0, 0, 0, 0, ID, "redir_off");
        chk("redir_flush_cnt", a_if.flush_events, 1);
        chk("redir_stall_cnt", a_if.stall_cycles, 1);
        do_reset("rst_tbl");
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].lu, vecs[i].exr, vecs[i].req, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_b", i), 32'(b_ctrl), 32'(vecs[i].exp));
        end
        step(0, 0, 0, 0, ID, "tbl_end");
        chk("tbl_stall_cnt", a_if.stall_cycles, 4);
        chk("tbl_flush_cnt", a_if.flush_events, 4);
        do_reset("rst_defer");
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, FZ, $sformatf("defer_frz%0d", i));
        step(0, 1, 1, 1, RD, "defer_ready");
        step(0, 0, 0, 0, ID, "defer_end");
        chk("defer_stall_cnt", a_if.stall_cycles, 3);
        chk("defer_flush_cnt", a_if.flush_events, 1);
        do_reset("rst_mid");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, FZ, $sformatf("mid_frz%0d", i));
        @(negedge clk);
        chk("mid_pre_stall", a_if.stall_cycles, 5);
        chk("mid_pre_bfault", 32'(b_if.mem_fault), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_async_a", 32'(a_ctrl), 32'(ID));
        chk("mid_async_b", 32'(b_ctrl), 32'(ID));
        chk("mid_async_stall", a_if.stall_cycles, 0);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        step(0, 0, 0, 0, ID, "mid_post");
        chk("mid_post_b", 32'(b_ctrl), 32'(ID));
        step(0, 1, 0, 0, RD, "mid_post_run");
        do_reset("rst_to");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, FZ, $sformatf("to_wait%0d", i));
            chk($sformatf("to_wait%0d_b", i), 32'(b_ctrl), 32'(FZ));
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, RD, $sformatf("to_drop%0d", i));
            chk($sformatf("to_drop%0d_b", i), 32'(b_ctrl), 32'(FT));
        end
        do_reset("rst_to_clr");
        do_reset("rst_sat");
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, LU, $sformatf("sat_a%0d", i));
        step(0, 0, 0, 0, ID, "sat_mid");
        chk("sat15_b", 32'(b_if.stall_cycles), 15);
        chk("sat15_a", a_if.stall_cycles, 15);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, LU, $sformatf("sat_b%0d", i));
        step(0, 0, 0, 0, ID, "sat_end");
        chk("sat18_b", 32'(b_if.stall_cycles), 15);
        chk("sat18_a", a_if.stall_cycles, 18);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32I pipeline.
- Arbitrates three hazard sources into one consistent set of per-register stall/flush controls:
  - load-use hazard from the hazard detection unit
  - taken branch/jump redirect from EX
  - multi-cycle data-memory wait from MEM
- Tracks memory-wait duration with an FSM and timeout fault.
- Keeps saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 16, max consecutive MEM-wait cycles before the fault latches (≥2).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- load_use_hazard  in  1  load-use hazard from hazard detection unit
- ex_redirect  in  1  EX-stage branch/jump taken (PC must change)
- dmem_req  in  1  MEM stage holds a load/store
- dmem_ready  in  1  data memory completes access this cycle
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID
- stall_id_ex  out  1  hold ID/EX
- stall_ex_mem  out  1  hold EX/MEM
- flush_if_id  out  1  zero IF/ID (bubble)
- flush_id_ex  out  1  zero ID/EX (bubble)
- flush_mem_wb  out  1  bubble into MEM/WB
- pc_redirect  out  1  select branch target for PC
- mem_fault  out  1  sticky timeout fault
- stall_cycles  out  CNT_W  cycles with stall_pc=1
- flush_events  out  CNT_W  redirects applied

Behaviour:
- Single clock domain. Reset is asynchronous, active-high on rst; clock is clk.
- Reset values:
  - FSM = RUN, wait_cnt = 0.
  - mem_fault, stall_cycles, flush_events = 0.
  - Combinational outputs are 0 while rst=1.
- FSM states: RUN, MEM_WAIT, FAULT (encoding in package).
- mem_freeze (combinational) = (dmem_req & ~dmem_ready) in RUN/MEM_WAIT, or state==FAULT.
- Transitions:
  - RUN -> MEM_WAIT on dmem_req & ~dmem_ready; wait_cnt <= 1.
  - MEM_WAIT -> RUN on dmem_ready, or if dmem_req drops; wait_cnt <= 0.
  - MEM_WAIT with ~dmem_ready: wait_cnt++. If wait_cnt == TIMEOUT-1, go to FAULT instead.
  - FAULT is absorbing until rst. mem_fault = 1 in FAULT.
- Output priority per cycle (highest first):
  1. mem_freeze:
     - stall_pc, stall_if_id, stall_id_ex, stall_ex_mem = 1; flush_mem_wb = 1.
     - pc_redirect, flush_if_id, flush_id_ex = 0.
     - ex_redirect is deferred: EX is frozen and holds it, so it is applied on the first unfrozen cycle.
  2. ex_redirect:
     - pc_redirect, flush_if_id, flush_id_ex = 1; all stalls = 0.
     - A simultaneous load_use_hazard is ignored, because its consumer is flushed.
  3. load_use_hazard:
     - stall_pc, stall_if_id = 1; flush_id_ex = 1. Others 0.
  4. Otherwise all control outputs are 0.
- Zero latency: all control outputs are combinational from state and current inputs.
- Counters:
  - stall_cycles increments on every cycle with stall_pc=1.
  - flush_events increments on every cycle with pc_redirect=1.
  - Both saturate at all-ones; no wrap.
- dmem_ready=1 on the first cycle of dmem_req: no freeze, state stays RUN.
- Reset mid-MEM_WAIT or mid-FAULT returns to RUN immediately (asynchronous).

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state typedef/localparams ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_FAULT=2'd2
  - default TIMEOUT and CNT_W constants
- One natural sub-module: sat_counter (CNT_W-wide, enable, async reset, saturating). Instantiated twice.

Test Plan:
- Reset asserted mid-MEM_WAIT (wait_cnt=5) -> all outputs 0, state RUN on the same edge; counters 0.
- load_use_hazard=1 for 1 cycle, others 0 -> stall_pc=stall_if_id=flush_id_ex=1 that cycle; stall_cycles=1 after the edge.
- ex_redirect=1 and load_use_hazard=1 together -> pc_redirect=flush_if_id=flush_id_ex=1, stall_pc=0; flush_events=1.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 with ex_redirect held high throughout:
  - 3 frozen cycles: all four stalls=1, flush_mem_wb=1, pc_redirect=0.
  - On the ready cycle: pc_redirect=1.
  - Afterwards stall_cycles=3, flush_events=1.
- TIMEOUT=4, dmem_ready held 0 -> FAULT entered after 4th cycle edge; mem_fault=1 sticky; pipeline stays frozen after dmem_req drops, until rst.
- stall_cycles preloaded near max (CNT_W=4, force 15 stall cycles then 3 more) -> stall_cycles stays 4'hF.
